// File: rtl/i2s_pkg.sv
// Shared constants and FSM encoding for the I2S frame capture slice.
package i2s_pkg;

    localparam int   I2S_DATA_W = 24;
    localparam int   I2S_CNT_W  = 6;
    localparam logic LEFT_CH    = 1'b0;
    localparam logic RIGHT_CH   = 1'b1;

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        SHIFT = 2'd1,
        PAD   = 2'd2
    } deser_state_e;

endpackage

// File: rtl/i2s_bit_deser.sv
// Oversampled I2S bit deserialiser: bck edge detect, slot-boundary detect, word shifter.
// Emits single-cycle word_done / short pulses in the cycle that samples the deciding bit.
module i2s_bit_deser
    import i2s_pkg::*;
#(
    parameter int DATA_W = I2S_DATA_W,
    parameter int CNT_W  = I2S_CNT_W
) (
    input  logic              mck,
    input  logic              reset_n,
    input  logic              i_bck,
    input  logic              i_lrck,
    input  logic              i_sdata,
    output logic [DATA_W-1:0] o_word,
    output logic              o_word_ch,
    output logic              o_word_done,
    output logic              o_short
);

    deser_state_e      r_state;
    deser_state_e      w_next;
    logic              r_bck_d;
    logic              r_lrck_at_rise;
    logic              r_ch;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-2:0] r_shift;
    logic              w_rise;
    logic              w_boundary;

    assign w_rise     = i_bck & ~r_bck_d;
    assign w_boundary = w_rise && (i_lrck != r_lrck_at_rise);
    // The LSB is taken straight from sdata so a word completes in the sampling cycle.
    assign o_word     = {r_shift, i_sdata};
    assign o_word_ch  = r_ch;

    always_ff @(posedge mck or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= HUNT;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            HUNT:    if (w_boundary) w_next = SHIFT;
            SHIFT:   if (w_boundary) w_next = SHIFT;
                     else if (o_word_done) w_next = PAD;
            PAD:     if (w_boundary) w_next = SHIFT;
            default: w_next = HUNT;
        endcase
    end

    always_comb begin
        o_word_done = 1'b0;
        o_short     = 1'b0;
        if (r_state == SHIFT) begin
            o_short     = w_boundary;
            o_word_done = w_rise && !w_boundary && (r_cnt == CNT_W'(DATA_W - 1));
        end
    end

    // A boundary bit is the I2S delay slot, so it is dropped rather than shifted.
    always_ff @(posedge mck or negedge reset_n) begin
        if (!reset_n) begin
            r_bck_d        <= 1'b0;
            r_lrck_at_rise <= 1'b0;
            r_ch           <= 1'b0;
            r_cnt          <= '0;
            r_shift        <= '0;
        end else begin
            r_bck_d <= i_bck;
            if (w_boundary) begin
                r_lrck_at_rise <= i_lrck;
                r_ch           <= i_lrck;
                r_cnt          <= '0;
                r_shift        <= '0;
            end else if (w_rise && r_state == SHIFT) begin
                r_shift <= o_word[DATA_W-2:0];
                r_cnt   <= r_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/i2s_frame_capture.sv
// I2S stereo frame capture: pairs left/right words into a valid/ready frame with sticky flags.
// Optional running peak meters are enabled with the macro I2S_FRAME_CAPTURE_PEAK_EN.
module i2s_frame_capture
    import i2s_pkg::*;
#(
    parameter int DATA_W = I2S_DATA_W,
    parameter int CNT_W  = I2S_CNT_W
) (
    input  logic              mck,
    input  logic              reset_n,
    input  logic              bck,
    input  logic              lrck,
    input  logic              sdata,
    output logic [DATA_W-1:0] out_left,
    output logic [DATA_W-1:0] out_right,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              overrun,
    output logic              short_err,
    input  logic              clr_err
`ifdef I2S_FRAME_CAPTURE_PEAK_EN
    ,
    input  logic              peak_clr,
    output logic [DATA_W-2:0] peak_left,
    output logic [DATA_W-2:0] peak_right
`endif
);

    logic [DATA_W-1:0] w_word;
    logic              w_word_ch;
    logic              w_word_done;
    logic              w_short;
    logic              w_frame_done;
    logic [DATA_W-1:0] r_hold;
    logic              r_left_pend;
    logic [DATA_W-1:0] r_out_left;
    logic [DATA_W-1:0] r_out_right;
    logic              r_out_valid;
    logic              r_overrun;
    logic              r_short_err;

    i2s_bit_deser #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_deser (
        .mck         (mck),
        .reset_n     (reset_n),
        .i_bck       (bck),
        .i_lrck      (lrck),
        .i_sdata     (sdata),
        .o_word      (w_word),
        .o_word_ch   (w_word_ch),
        .o_word_done (w_word_done),
        .o_short     (w_short)
    );

    assign w_frame_done = w_word_done && (w_word_ch == RIGHT_CH) && r_left_pend;

    assign out_left  = r_out_left;
    assign out_right = r_out_right;
    assign out_valid = r_out_valid;
    assign overrun   = r_overrun;
    assign short_err = r_short_err;

    // A right word only forms a frame when a left word is waiting for it.
    always_ff @(posedge mck or negedge reset_n) begin
        if (!reset_n) begin
            r_hold      <= '0;
            r_left_pend <= 1'b0;
            r_out_left  <= '0;
            r_out_right <= '0;
        end else if (w_short) begin
            r_left_pend <= 1'b0;
        end else if (w_word_done) begin
            if (w_word_ch == LEFT_CH) begin
                r_hold      <= w_word;
                r_left_pend <= 1'b1;
            end else if (r_left_pend) begin
                r_out_left  <= r_hold;
                r_out_right <= w_word;
                r_left_pend <= 1'b0;
            end
        end
    end

    always_ff @(posedge mck or negedge reset_n) begin
        if (!reset_n) begin
            r_out_valid <= 1'b0;
            r_overrun   <= 1'b0;
            r_short_err <= 1'b0;
        end else begin
            if (w_frame_done) begin
                r_out_valid <= 1'b1;
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_frame_done && r_out_valid && !out_ready) begin
                r_overrun <= 1'b1;
            end else if (clr_err) begin
                r_overrun <= 1'b0;
            end
            if (w_short) begin
                r_short_err <= 1'b1;
            end else if (clr_err) begin
                r_short_err <= 1'b0;
            end
        end
    end

`ifdef I2S_FRAME_CAPTURE_PEAK_EN
    logic [DATA_W-2:0] r_peak_left;
    logic [DATA_W-2:0] r_peak_right;
    logic [DATA_W-2:0] w_mag_left;
    logic [DATA_W-2:0] w_mag_right;

    // The most negative code has no positive twin, so it saturates to all-ones.
    function automatic logic [DATA_W-2:0] magnitude(input logic [DATA_W-1:0] x);
        logic [DATA_W-1:0] neg;
        neg = -x;
        if (!x[DATA_W-1]) begin
            return x[DATA_W-2:0];
        end else if (x[DATA_W-2:0] == '0) begin
            return '1;
        end else begin
            return neg[DATA_W-2:0];
        end
    endfunction

    assign w_mag_left  = magnitude(r_hold);
    assign w_mag_right = magnitude(w_word);
    assign peak_left   = r_peak_left;
    assign peak_right  = r_peak_right;

    always_ff @(posedge mck or negedge reset_n) begin
        if (!reset_n) begin
            r_peak_left  <= '0;
            r_peak_right <= '0;
        end else if (peak_clr) begin
            r_peak_left  <= '0;
            r_peak_right <= '0;
        end else if (w_frame_done) begin
            if (w_mag_left > r_peak_left) r_peak_left <= w_mag_left;
            if (w_mag_right > r_peak_right) r_peak_right <= w_mag_right;
        end
    end
`endif

endmodule

// File: tb/tb_i2s_frame_capture.sv
// Scoreboard bench for i2s_frame_capture: a bit-level I2S driver pushes expected frames,
// a monitor pops and compares on every accepted frame. Peak checks need I2S_FRAME_CAPTURE_PEAK_EN.
module tb_i2s_frame_capture;

    logic        mck;
    logic        reset_n;
    logic        bck;
    logic        lrck;
    logic        sdata;
    logic [23:0] out_left;
    logic [23:0] out_right;
    logic        out_valid;
    logic        out_ready;
    logic        overrun;
    logic        short_err;
    logic        clr_err;
`ifdef I2S_FRAME_CAPTURE_PEAK_EN
    logic        peak_clr;
    logic [22:0] peak_left;
    logic [22:0] peak_right;
`endif

    int          nCompared;
    int          nMismatched;
    logic [47:0] expQ[$];

    i2s_frame_capture dut (
        .mck        (mck),
        .reset_n    (reset_n),
        .bck        (bck),
        .lrck       (lrck),
        .sdata      (sdata),
        .out_left   (out_left),
        .out_right  (out_right),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .overrun    (overrun),
        .short_err  (short_err),
        .clr_err    (clr_err)
`ifdef I2S_FRAME_CAPTURE_PEAK_EN
        ,
        .peak_clr   (peak_clr),
        .peak_left  (peak_left),
        .peak_right (peak_right)
`endif
    );

    initial mck = 1'b0;
    always #5 mck = ~mck;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // One bck period = 4 mck; lrck/sdata change with the falling bck edge.
    task automatic bckCycle(input logic lr, input logic d, input bit setReady);
        @(negedge mck);
        bck = 1'b0; lrck = lr; sdata = d;
        @(negedge mck);
        @(negedge mck);
        bck = 1'b1;
        if (setReady) out_ready = 1'b1;
        @(negedge mck);
    endtask

    // Bit 0 is the delay slot, bits 1..24 carry the word MSB first, the rest are pad.
    task automatic sendSlot(input logic lr, input logic [23:0] w, input int nBck, input bit readyAtLsb);
        for (int k = 0; k < nBck; k++) begin
            logic d;
            d = 1'b1;
            if (k >= 1 && k <= 24) d = w[24-k];
            bckCycle(lr, d, readyAtLsb && (k == 24));
        end
    endtask

    task automatic applyStimulus(input logic [23:0] l, input logic [23:0] r, input int leftBck,
                                 input bit expectEmit, input bit readyAtLsb);
        if (expectEmit) expQ.push_back({l, r});
        sendSlot(1'b0, l, leftBck, 1'b0);
        sendSlot(1'b1, r, 32, readyAtLsb);
    endtask

    initial begin
        logic [47:0] exp;
        forever begin
            @(negedge mck);
            #1;
            if (reset_n && out_valid && out_ready) begin
                nCompared++;
                if (expQ.size() == 0) begin
                    nMismatched++;
                    $display("[TB] FAIL unexpectedFrame: got %h/%h, expected no frame", out_left, out_right);
                end else begin
                    exp = expQ.pop_front();
                    if ({out_left, out_right} !== exp) begin
                        nMismatched++;
                        $display("[TB] FAIL frame: got %h/%h, expected %h/%h",
                                 out_left, out_right, exp[47:24], exp[23:0]);
                    end
                end
            end
        end
    end

    initial begin
        nCompared = 0;
        nMismatched = 0;
        reset_n = 1'b0; bck = 1'b0; lrck = 1'b0; sdata = 1'b0;
        out_ready = 1'b1; clr_err = 1'b0;
`ifdef I2S_FRAME_CAPTURE_PEAK_EN
        peak_clr = 1'b0;
`endif
        repeat (3) @(negedge mck);
        #1;
        checkOutput("resetLeft", 32'(out_left), 32'h0);
        checkOutput("resetRight", 32'(out_right), 32'h0);
        checkOutput("resetValid", 32'(out_valid), 32'h0);
        checkOutput("resetFlags", {30'd0, overrun, short_err}, 32'h0);
        @(negedge mck);
        reset_n = 1'b1;

        $display("[TB] normal stream");
        applyStimulus(24'h888888, 24'hF0F0F0, 32, 1'b0, 1'b0);
        repeat (3) applyStimulus(24'h888888, 24'hF0F0F0, 32, 1'b1, 1'b0);
        checkOutput("normalFlags", {30'd0, overrun, short_err}, 32'h0);
        checkOutput("normalDrained", 32'(expQ.size()), 32'h0);

        $display("[TB] overrun");
        @(negedge mck);
        out_ready = 1'b0;
        applyStimulus(24'h111111, 24'h222222, 32, 1'b0, 1'b0);
        applyStimulus(24'h123456, 24'h612345, 32, 1'b1, 1'b0);
        repeat (2) @(negedge mck);
        #1;
        checkOutput("overrunLeft", 32'(out_left), 32'h123456);
        checkOutput("overrunRight", 32'(out_right), 32'h612345);
        checkOutput("overrunValid", 32'(out_valid), 32'h1);
        checkOutput("overrunFlag", 32'(overrun), 32'h1);
        @(negedge mck);
        clr_err = 1'b1;
        @(negedge mck);
        clr_err = 1'b0;
        #1;
        checkOutput("overrunCleared", 32'(overrun), 32'h0);
        out_ready = 1'b1;

        $display("[TB] short slot");
        applyStimulus(24'hABCDEF, 24'h13579B, 11, 1'b0, 1'b0);
        #1;
        checkOutput("shortFlag", 32'(short_err), 32'h1);
        applyStimulus(24'h5A5A5A, 24'hA5C3E1, 32, 1'b1, 1'b0);

        $display("[TB] reset mid right word");
        sendSlot(1'b0, 24'hC0FFEE, 32, 1'b0);
        sendSlot(1'b1, 24'h0BADED, 13, 1'b0);
        @(negedge mck);
        reset_n = 1'b0; bck = 1'b0; lrck = 1'b0; sdata = 1'b0;
        #1;
        checkOutput("midResetLeft", 32'(out_left), 32'h0);
        checkOutput("midResetRight", 32'(out_right), 32'h0);
        checkOutput("midResetValid", 32'(out_valid), 32'h0);
        checkOutput("midResetFlags", {30'd0, overrun, short_err}, 32'h0);
        repeat (3) @(negedge mck);
        reset_n = 1'b1;
        applyStimulus(24'hAAAAAA, 24'h555555, 32, 1'b0, 1'b0);
        applyStimulus(24'h1F3AF0, 24'hE0C50F, 32, 1'b1, 1'b0);

        $display("[TB] accept in completion cycle");
        @(negedge mck);
        out_ready = 1'b0;
        applyStimulus(24'h0F1E2D, 24'h3C4B5A, 32, 1'b1, 1'b0);
        applyStimulus(24'h700001, 24'h8000FF, 32, 1'b1, 1'b1);
        repeat (4) @(negedge mck);
        #1;
        checkOutput("sameCycleOverrun", 32'(overrun), 32'h0);
        checkOutput("sameCycleValid", 32'(out_valid), 32'h0);

`ifdef I2S_FRAME_CAPTURE_PEAK_EN
        $display("[TB] peak meters");
        @(negedge mck);
        peak_clr = 1'b1;
        @(negedge mck);
        peak_clr = 1'b0;
        #1;
        checkOutput("peakClrLeft", 32'(peak_left), 32'h0);
        checkOutput("peakClrRight", 32'(peak_right), 32'h0);
        applyStimulus(24'h800000, 24'h000005, 32, 1'b1, 1'b0);
        applyStimulus(24'h000010, 24'hFFFFF0, 32, 1'b1, 1'b0);
        #1;
        checkOutput("peakLeft", 32'(peak_left), 32'h7FFFFF);
        checkOutput("peakRight", 32'(peak_right), 32'h000010);
        @(negedge mck);
        peak_clr = 1'b1;
        @(negedge mck);
        peak_clr = 1'b0;
        #1;
        checkOutput("peakClrAgain", {9'd0, peak_left} | {9'd0, peak_right}, 32'h0);
`endif

        repeat (20) @(negedge mck);
        #1;
        checkOutput("queueEmpty", 32'(expQ.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
